// File: rtl/rv32v_param_reorder_buffer.sv
// Vector reorder buffer: circular entry store with per-lane completion,
// multi-port FU writeback, in-order commit and exception self-flush.
module rv32v_param_reorder_buffer #(
  parameter  int NUM_ENTRIES = 32,
  parameter  int LANES       = 4,
  parameter  int LANE_W      = 32,
  parameter  int NUM_FU      = 4,
  localparam int IDX_W       = $clog2(NUM_ENTRIES),
  localparam int LW          = $clog2(LANES)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     alloc_ena,
  input  logic [4:0]               alloc_vd,
  input  logic [LANES-1:0]         alloc_lane_mask,
  output logic [IDX_W-1:0]         cur_tail,
  output logic                     full,
  output logic                     empty,
  output logic [IDX_W:0]           count,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*IDX_W-1:0]  fu_idx,
  input  logic [NUM_FU*LW-1:0]     fu_lane,
  input  logic [NUM_FU*LANE_W-1:0] fu_data,
  input  logic [NUM_FU-1:0]        fu_exc,
  input  logic                     flush,
  input  logic                     commit_ena,
  output logic                     commit_valid,
  output logic [4:0]               commit_vd,
  output logic [LANES-1:0]         commit_wen,
  output logic [LANES*LANE_W-1:0]  commit_wdata,
  output logic                     commit_done,
  output logic                     v_exception
);

  logic [NUM_ENTRIES-1:0]            valid_q, valid_d;
  logic [NUM_ENTRIES-1:0][LANES-1:0] done_q, done_d;
  logic [NUM_ENTRIES-1:0]            exc_q, exc_d;
  logic [LANES-1:0]                  exp_q [NUM_ENTRIES];
  logic [4:0]                        vd_q [NUM_ENTRIES];
  logic [LANE_W-1:0]                 data_q [NUM_ENTRIES][LANES];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             cdone_q, cdone_d;
  logic             vexc_q, vexc_d;

  logic [IDX_W-1:0]  f_idx [NUM_FU];
  logic [LW-1:0]     f_lane [NUM_FU];
  logic [NUM_FU-1:0] fu_hit;
  logic              alloc_fire;
  logic              commit_fire;
  logic              flush_all;

  assign full  = (cnt_q == (IDX_W+1)'(NUM_ENTRIES));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign cur_tail = tail_q;

  assign commit_valid = valid_q[head_q] &
                        (done_q[head_q] == exp_q[head_q]);
  assign commit_vd  = vd_q[head_q];
  assign commit_wen = exp_q[head_q];

  always_comb begin
    commit_wdata = '0;
    for (int l = 0; l < LANES; l++)
      commit_wdata[l*LANE_W +: LANE_W] = data_q[head_q][l];
  end

  assign alloc_fire  = alloc_ena & ~full & ~flush;
  assign commit_fire = commit_valid & commit_ena & ~flush;
  // A faulting retire wipes the whole buffer on the same edge.
  assign flush_all   = flush | (commit_fire & exc_q[head_q]);

  always_comb begin
    fu_hit = '0;
    for (int p = 0; p < NUM_FU; p++) begin
      f_idx[p]  = fu_idx[p*IDX_W +: IDX_W];
      f_lane[p] = fu_lane[p*LW +: LW];
      fu_hit[p] = fu_valid[p] & valid_q[f_idx[p]] &
                  exp_q[f_idx[p]][f_lane[p]];
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    cdone_d = commit_fire;
    vexc_d  = commit_fire & exc_q[head_q];
    if (flush_all) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
    end else begin
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = '0;
        exc_d[tail_q]   = 1'b0;
        tail_d          = tail_q + IDX_W'(1);
      end
      for (int p = 0; p < NUM_FU; p++) begin
        if (fu_hit[p]) begin
          done_d[f_idx[p]][f_lane[p]] = 1'b1;
          exc_d[f_idx[p]] = exc_d[f_idx[p]] | fu_exc[p];
        end
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = '0;
        exc_d[head_q]   = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end
      cnt_d = cnt_q + (IDX_W+1)'(alloc_fire)
                    - (IDX_W+1)'(commit_fire);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      cdone_q <= 1'b0;
      vexc_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      cdone_q <= cdone_d;
      vexc_q  <= vexc_d;
    end
  end

  // Payload is qualified by valid/done, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (alloc_fire) begin
      vd_q[tail_q]  <= alloc_vd;
      exp_q[tail_q] <= alloc_lane_mask;
    end
    for (int p = NUM_FU-1; p >= 0; p--) begin
      if (fu_hit[p])
        data_q[f_idx[p]][f_lane[p]] <= fu_data[p*LANE_W +: LANE_W];
    end
  end

  assign commit_done = cdone_q;
  assign v_exception = vexc_q;

endmodule

// File: tb/tb_rv32v_param_reorder_buffer.sv
// Directed bench for the vector reorder buffer: fill, ordering,
// port conflict, exception, flush collision and async reset.
module tb_rv32v_param_reorder_buffer;

  localparam int N  = 32;
  localparam int L  = 4;
  localparam int W  = 32;
  localparam int F  = 4;
  localparam int IW = 5;
  localparam int LB = 2;

  logic           CLK;
  logic           nRST;
  logic           alloc_ena;
  logic [4:0]     alloc_vd;
  logic [L-1:0]   alloc_lane_mask;
  logic [IW-1:0]  cur_tail;
  logic           full;
  logic           empty;
  logic [IW:0]    count;
  logic [F-1:0]   fu_valid;
  logic [F*IW-1:0] fu_idx;
  logic [F*LB-1:0] fu_lane;
  logic [F*W-1:0] fu_data;
  logic [F-1:0]   fu_exc;
  logic           flush;
  logic           commit_ena;
  logic           commit_valid;
  logic [4:0]     commit_vd;
  logic [L-1:0]   commit_wen;
  logic [L*W-1:0] commit_wdata;
  logic           commit_done;
  logic           v_exception;

  int errs = 0;
  int checks = 0;

  rv32v_param_reorder_buffer #(
    .NUM_ENTRIES(N), .LANES(L), .LANE_W(W), .NUM_FU(F)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .alloc_ena(alloc_ena), .alloc_vd(alloc_vd),
    .alloc_lane_mask(alloc_lane_mask),
    .cur_tail(cur_tail), .full(full), .empty(empty),
    .count(count),
    .fu_valid(fu_valid), .fu_idx(fu_idx), .fu_lane(fu_lane),
    .fu_data(fu_data), .fu_exc(fu_exc),
    .flush(flush), .commit_ena(commit_ena),
    .commit_valid(commit_valid), .commit_vd(commit_vd),
    .commit_wen(commit_wen), .commit_wdata(commit_wdata),
    .commit_done(commit_done), .v_exception(v_exception)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic fu_set(input int p, input logic [IW-1:0] idx,
                        input logic [LB-1:0] lane,
                        input logic [W-1:0] data, input logic exc);
    fu_valid[p] = 1'b1;
    fu_idx[p*IW +: IW] = idx;
    fu_lane[p*LB +: LB] = lane;
    fu_data[p*W +: W] = data;
    fu_exc[p] = exc;
  endtask

  task automatic fu_clr();
    fu_valid = '0;
    fu_exc   = '0;
  endtask

  task automatic alloc(input logic [4:0] vd, input logic [L-1:0] m);
    alloc_ena = 1'b1;
    alloc_vd = vd;
    alloc_lane_mask = m;
    step();
    alloc_ena = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    alloc_ena = 0; alloc_vd = 0; alloc_lane_mask = 0;
    fu_valid = 0; fu_idx = 0; fu_lane = 0; fu_data = 0; fu_exc = 0;
    flush = 0; commit_ena = 0;
    #3;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_tail", cur_tail, 0);
    check("rst_cvalid", commit_valid, 0);
    check("rst_cdone", commit_done, 0);
    check("rst_vexc", v_exception, 0);
    nRST = 1'b1;
    step();

    // fill
    alloc_ena = 1'b1; alloc_vd = 5'd1; alloc_lane_mask = 4'hf;
    step();
    check("fill_cnt1", count, 1);
    check("fill_tail1", cur_tail, 1);
    repeat (31) step();
    check("fill_full", full, 1);
    check("fill_cnt32", count, 32);
    check("fill_tail_wrap", cur_tail, 0);
    step();
    alloc_ena = 1'b0;
    check("fill_33_cnt", count, 32);
    check("fill_33_tail", cur_tail, 0);
    do_flush();
    check("flush_empty", empty, 1);
    check("flush_cnt", count, 0);

    // out-of-order completion
    alloc(5'd3, 4'hf);
    alloc(5'd7, 4'hf);
    for (int l = 0; l < 4; l++)
      fu_set(l, 5'd1, LB'(l), 32'h100 + l, 1'b0);
    step();
    fu_clr();
    check("ooo_wait1", commit_valid, 0);
    for (int l = 0; l < 3; l++)
      fu_set(l, 5'd0, LB'(l), 32'h200 + l, 1'b0);
    step();
    fu_clr();
    check("ooo_wait2", commit_valid, 0);
    fu_set(3, 5'd0, 2'd3, 32'h203, 1'b0);
    step();
    fu_clr();
    check("ooo_cv0", commit_valid, 1);
    check("ooo_vd0", commit_vd, 3);
    check("ooo_wen0", commit_wen, 4'hf);
    check("ooo_data0", commit_wdata,
          128'h00000203_00000202_00000201_00000200);
    commit_ena = 1'b1;
    step();
    check("ooo_done0", commit_done, 1);
    check("ooo_noexc", v_exception, 0);
    check("ooo_cnt1", count, 1);
    check("ooo_vd1", commit_vd, 7);
    check("ooo_data1", commit_wdata,
          128'h00000103_00000102_00000101_00000100);
    step();
    check("ooo_done1", commit_done, 1);
    check("ooo_empty", empty, 1);
    commit_ena = 1'b0;
    step();
    check("ooo_done_end", commit_done, 0);

    // port conflict on entry 3 lane 1
    do_flush();
    alloc(5'd2, 4'h0);
    check("zero_mask_cv", commit_valid, 1);
    alloc(5'd2, 4'h0);
    alloc(5'd2, 4'h0);
    alloc(5'd9, 4'h7);
    fu_set(0, 5'd3, 2'd1, 32'hA, 1'b0);
    fu_set(1, 5'd3, 2'd0, 32'hC, 1'b0);
    fu_set(2, 5'd3, 2'd1, 32'hB, 1'b0);
    fu_set(3, 5'd3, 2'd2, 32'hD, 1'b0);
    step();
    fu_clr();
    commit_ena = 1'b1;
    repeat (3) step();
    commit_ena = 1'b0;
    check("pc_cnt", count, 1);
    check("pc_cv", commit_valid, 1);
    check("pc_vd", commit_vd, 9);
    check("pc_wen", commit_wen, 4'h7);
    check("pc_data", {32'h0, commit_wdata[95:0]},
          128'h0000000D_0000000A_0000000C);

    // exception self-flush with 5 valid entries
    do_flush();
    repeat (5) alloc(5'd4, 4'h1);
    fu_set(1, 5'd0, 2'd0, 32'h55, 1'b1);
    step();
    fu_clr();
    check("exc_cnt5", count, 5);
    check("exc_cv", commit_valid, 1);
    commit_ena = 1'b1;
    step();
    commit_ena = 1'b0;
    check("exc_done", commit_done, 1);
    check("exc_vexc", v_exception, 1);
    check("exc_cnt0", count, 0);
    check("exc_tail0", cur_tail, 0);
    step();
    check("exc_done_end", commit_done, 0);
    check("exc_vexc_end", v_exception, 0);

    // flush vs alloc vs commit
    alloc(5'd6, 4'h0);
    check("col_cv", commit_valid, 1);
    flush = 1'b1; alloc_ena = 1'b1; commit_ena = 1'b1;
    step();
    flush = 1'b0; alloc_ena = 1'b0; commit_ena = 1'b0;
    check("col_cnt", count, 0);
    check("col_tail", cur_tail, 0);
    check("col_done", commit_done, 0);
    check("col_cv0", commit_valid, 0);
    step();
    check("col_done2", commit_done, 0);

    // async reset while half full
    alloc_ena = 1'b1; alloc_lane_mask = 4'hf;
    repeat (16) step();
    alloc_ena = 1'b0;
    check("ar_cnt16", count, 16);
    #2 nRST = 1'b0;
    #1;
    check("ar_empty", empty, 1);
    check("ar_cnt0", count, 0);
    check("ar_tail0", cur_tail, 0);
    #1 nRST = 1'b1;
    step();
    check("ar_after", count, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
